kb_line_buffer: RTL and testbench
=================================

// Module: kb_line_buffer
// PURPOSE
//   Parametrised keyboard line assembler. It collects accepted key codes into a
//   MAX_CHARS-deep line and handles backspace and overflow. On the terminator key
//   it presents the packed line with its length over a valid/ready handshake.
//   Sits between the keyboard decoder and the command parser. Successor to the
//   fixed 4-char linefeed buffer.
// PARAMETERS
//   DATA_W    8      width of one key code
//   MAX_CHARS 8      line capacity in characters (>=1)
//   KEY_TERM  8'h0D  terminator code (ends line)
//   KEY_BS    8'h08  backspace code (deletes last char)
//   PAD       8'h00  fill value for unused char slots
// PORTS
//   clk           in   1                   clock, all logic on posedge
//   rst           in   1                   reset, synchronous, active-high
//   key           in   DATA_W              key code
//   key_valid     in   1                   key strobe, one code per cycle
//   key_ready     out  1                   1 = block accepts key this cycle
//   line_out      out  MAX_CHARS*DATA_W    packed line, char0 in MSBs
//   line_len      out  $clog2(MAX_CHARS+1) number of valid chars in line_out
//   line_overflow out  1                   >=1 char dropped on this line (full)
//   line_valid    out  1                   line_out/len/overflow valid
//   line_ready    in   1                   consumer accepts line
// BEHAVIOUR
//   - Reset: state=COLLECT, count=0, all slots=PAD, line_out=PAD-filled,
//     line_len=0, line_overflow=0, line_valid=0, sticky ovf=0.
//   - key_ready = (state==COLLECT), combinational from state.
//     accept = key_valid & key_ready & ~rst.
//   - key_valid while key_ready=0 is ignored and dropped. It is not queued.
//   - COLLECT, on accept:
//     * key==KEY_TERM:
//       - line_out <= slots (slot i at bits [(MAX_CHARS-i)*DATA_W-1 -: DATA_W]).
//       - line_len <= count; line_overflow <= ovf; line_valid <= 1; -> HOLD.
//       - Terminator is not stored. Empty line is legal (line_len=0).
//     * key==KEY_BS:
//       - count>0: count--, slot[count-1] <= PAD.
//       - count==0: no effect.
//       - ovf is not cleared by BS.
//     * other key:
//       - count<MAX_CHARS: slot[count] <= key, count++.
//       - count==MAX_CHARS: key dropped, ovf <= 1.
//     * KEY_TERM takes priority over KEY_BS if the parameters are equal.
//   - Latency: line_valid rises the cycle after the terminator is accepted.
//   - HOLD:
//     * line_valid=1; line_out/line_len/line_overflow held stable.
//     * On line_ready=1: line_valid <= 0, count <= 0, slots <= PAD, ovf <= 0,
//       -> COLLECT.
//     * The first new key can be accepted the cycle after the handshake.
//     * line_out/len/overflow keep the last line until the next terminator.
//   - line_ready while line_valid=0 has no effect.
//   - Reset mid-line or in HOLD: the partial/pending line is discarded and all
//     state returns to reset values next cycle.
//   - count width = $clog2(MAX_CHARS+1); no wrap-around, saturates at MAX_CHARS.
// TESTING (DATA_W=8, MAX_CHARS=4, KEY_TERM=0D, KEY_BS=08, PAD=00)
//   1. keys 41,42,43,0D; line_ready=1 -> line_valid 1 cycle after 0D,
//      line_out=41424300, len=3, ovf=0; line_valid drops next cycle.
//   2. keys 41,42,08,43,0D -> line_out=41430000, len=2; 08 at count=0 -> no change.
//   3. keys 31,32,33,34,35,36,0D -> line_out=31323334, len=4, ovf=1;
//      next line 39,0D -> 39000000, len=1, ovf=0.
//   4. 0D with empty line -> line_valid=1, len=0, line_out=00000000.
//   5. line_ready=0 for 10 cycles after line; drive 41 during HOLD -> key_ready=0,
//      outputs stable, 41 absent from next line.
//   6. keys 41,42, then rst 1 cycle, then 43,0D -> line_out=43000000, len=1;
//      rst asserted in HOLD -> line_valid=0 next cycle.

Source files
------------

// File: rtl/kb_line_buffer.sv
`default_nettype none
// ============================================================================
// kb_line_buffer : assembles key codes into a line, presents it on TERM key
// Revision: 1.0
// ============================================================================
module kb_line_buffer #(
  parameter int              DATA_W    = 8,
  parameter int              MAX_CHARS = 8,
  parameter logic [DATA_W-1:0] KEY_TERM  = 'h0D,
  parameter logic [DATA_W-1:0] KEY_BS    = 'h08,
  parameter logic [DATA_W-1:0] PAD       = 'h00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             key,
  input  logic                          key_valid,
  output logic                          key_ready,
  output logic [MAX_CHARS*DATA_W-1:0]   line_out,
  output logic [$clog2(MAX_CHARS+1)-1:0] line_len,
  output logic                          line_overflow,
  output logic                          line_valid,
  input  logic                          line_ready
);

  localparam int CNT_W = $clog2(MAX_CHARS + 1);
  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_CHARS);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                                state_q, state_d;
  logic [CNT_W-1:0]                      count_q, count_d;
  logic                                  ovf_q, ovf_d;
  // Element 0 is the most significant slot, so the packed array maps
  // directly onto line_out with char0 in the MSBs.
  logic [0:MAX_CHARS-1][DATA_W-1:0]      slots_q, slots_d;
  logic [MAX_CHARS*DATA_W-1:0]           line_out_q, line_out_d;
  logic [CNT_W-1:0]                      line_len_q, line_len_d;
  logic                                  line_ovf_q, line_ovf_d;
  logic                                  line_valid_q, line_valid_d;
  logic                                  w_accept;

  assign key_ready     = (state_q == COLLECT);
  assign w_accept      = key_valid & key_ready & ~rst;
  assign line_out      = line_out_q;
  assign line_len      = line_len_q;
  assign line_overflow = line_ovf_q;
  assign line_valid    = line_valid_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    slots_d      = slots_q;
    line_out_d   = line_out_q;
    line_len_d   = line_len_q;
    line_ovf_d   = line_ovf_q;
    line_valid_d = line_valid_q;
    case (state_q)
      COLLECT: begin
        if (w_accept) begin
          if (key == KEY_TERM) begin
            line_out_d   = slots_q;
            line_len_d   = count_q;
            line_ovf_d   = ovf_q;
            line_valid_d = 1'b1;
            state_d      = HOLD;
          end else if (key == KEY_BS) begin
            if (count_q != '0) begin
              count_d = count_q - 1'b1;
              for (int i = 0; i < MAX_CHARS; i++) begin
                if (i == int'(count_q) - 1) slots_d[i] = PAD;
              end
            end
          end else if (count_q < C_MAX_CNT) begin
            count_d = count_q + 1'b1;
            for (int i = 0; i < MAX_CHARS; i++) begin
              if (i == int'(count_q)) slots_d[i] = key;
            end
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (line_ready) begin
          line_valid_d = 1'b0;
          count_d      = '0;
          ovf_d        = 1'b0;
          slots_d      = {MAX_CHARS{PAD}};
          state_d      = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      slots_q      <= {MAX_CHARS{PAD}};
      line_out_q   <= {MAX_CHARS{PAD}};
      line_len_q   <= '0;
      line_ovf_q   <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      slots_q      <= slots_d;
      line_out_q   <= line_out_d;
      line_len_q   <= line_len_d;
      line_ovf_q   <= line_ovf_d;
      line_valid_q <= line_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kb_line_buffer.sv
`default_nettype none
// ============================================================================
// tb_kb_line_buffer : directed + random checks of kb_line_buffer vs a queue model
// Revision: 1.0
// ============================================================================
module tb_kb_line_buffer;

  localparam int N = 4;
  localparam logic [7:0] TERM = 8'h0D;
  localparam logic [7:0] BS   = 8'h08;
  localparam logic [7:0] PADV = 8'h00;

  logic          clk;
  logic          rst;
  logic [7:0]    key;
  logic          key_valid;
  logic          key_ready;
  logic [N*8-1:0] line_out;
  logic [2:0]    line_len;
  logic          line_overflow;
  logic          line_valid;
  logic          line_ready;

  kb_line_buffer #(
    .DATA_W(8), .MAX_CHARS(N), .KEY_TERM(TERM), .KEY_BS(BS), .PAD(PADV)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid),
    .key_ready(key_ready), .line_out(line_out), .line_len(line_len),
    .line_overflow(line_overflow), .line_valid(line_valid),
    .line_ready(line_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the line as a queue of characters plus a sticky flag.
  logic [7:0]     m_line[$];
  logic           m_ovf;
  logic           m_hold;
  logic [N*8-1:0] e_out;
  logic [2:0]     e_len;
  logic           e_ovf;
  logic           e_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_line.delete();
    m_ovf   = 1'b0;
    m_hold  = 1'b0;
    e_out   = {N{PADV}};
    e_len   = 3'd0;
    e_ovf   = 1'b0;
    e_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 64'(line_valid), 64'(e_valid));
    check({tag, "_out"},   64'(line_out),   64'(e_out));
    check({tag, "_len"},   64'(line_len),   64'(e_len));
    check({tag, "_ovf"},   64'(line_overflow), 64'(e_ovf));
  endtask

  task automatic step(input logic kv, input logic [7:0] k, input logic lr, input logic r);
    key_valid  = kv;
    key        = k;
    line_ready = lr;
    rst        = r;
    #1;
    check("key_ready", 64'(key_ready), 64'(!m_hold));
    if (r) begin
      model_reset();
    end else if (!m_hold) begin
      if (kv) begin
        if (k == TERM) begin
          for (int i = 0; i < N; i++)
            e_out[(N-i)*8-1 -: 8] = (i < m_line.size()) ? m_line[i] : PADV;
          e_len   = 3'(m_line.size());
          e_ovf   = m_ovf;
          e_valid = 1'b1;
          m_hold  = 1'b1;
        end else if (k == BS) begin
          if (m_line.size() > 0) void'(m_line.pop_back());
        end else if (m_line.size() < N) begin
          m_line.push_back(k);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end else if (lr) begin
      e_valid = 1'b0;
      m_line.delete();
      m_ovf  = 1'b0;
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs("step");
  endtask

  task automatic send(input logic [7:0] k);
    step(1'b1, k, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic lr);
    step(1'b0, 8'h00, lr, 1'b0);
  endtask

  initial begin
    logic [7:0] rk;
    key_valid  = 1'b0;
    key        = 8'h00;
    line_ready = 1'b0;
    rst        = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset_key_ready", 64'(key_ready), 64'(1'b1));

    // Line with immediate consumer
    step(1'b1, 8'h41, 1'b1, 1'b0);
    step(1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b1, 8'h43, 1'b1, 1'b0);
    step(1'b1, TERM, 1'b1, 1'b0);
    check("t1_out", 64'(line_out), 64'h41424300);
    check("t1_len", 64'(line_len), 64'd3);
    check("t1_valid", 64'(line_valid), 64'd1);
    idle(1'b1);
    check("t1_drop", 64'(line_valid), 64'd0);

    // Backspace at empty line, then mid-line
    send(BS);
    send(8'h41); send(8'h42); send(BS); send(8'h43); send(TERM);
    check("t2_out", 64'(line_out), 64'h41430000);
    check("t2_len", 64'(line_len), 64'd2);
    idle(1'b1);

    // Overflow then a clean line
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    send(8'h35); send(8'h36); send(TERM);
    check("t3_out", 64'(line_out), 64'h31323334);
    check("t3_len", 64'(line_len), 64'd4);
    check("t3_ovf", 64'(line_overflow), 64'd1);
    idle(1'b1);
    send(8'h39); send(TERM);
    check("t3b_out", 64'(line_out), 64'h39000000);
    check("t3b_len", 64'(line_len), 64'd1);
    check("t3b_ovf", 64'(line_overflow), 64'd0);
    idle(1'b1);

    // Empty line
    send(TERM);
    check("t4_valid", 64'(line_valid), 64'd1);
    check("t4_len", 64'(line_len), 64'd0);
    check("t4_out", 64'(line_out), 64'h00000000);
    idle(1'b1);

    // Keys during HOLD are dropped
    send(8'h55); send(TERM);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h41, 1'b0, 1'b0);
    check("t5_hold_out", 64'(line_out), 64'h55000000);
    idle(1'b1);
    send(TERM);
    check("t5_next_len", 64'(line_len), 64'd0);
    idle(1'b1);

    // Reset mid-line and in HOLD
    send(8'h41); send(8'h42);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send(8'h43); send(TERM);
    check("t6_out", 64'(line_out), 64'h43000000);
    check("t6_len", 64'(line_len), 64'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t6_rst_valid", 64'(line_valid), 64'd0);
    check("t6_rst_out", 64'(line_out), 64'h00000000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    rk = TERM;
        2:       rk = BS;
        default: rk = 8'($urandom_range(8'h20, 8'h7E));
      endcase
      step(($urandom_range(0, 9) < 7), rk, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
